// File: rtl/ysyx_22040759_id_queue.sv
// Decode-front instruction queue: circular FIFO head with load-use stall and forwarding selects.
// Optional zero-latency bypass of an empty queue when ID_QUEUE_BYPASS_EN is defined.
module ysyx_22040759_id_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fs_to_ds_valid,
    input  logic [32+PC_W-1:0]      fs_to_ds_bus,
    output logic                    ds_allowin,
    input  logic                    es_allowin,
    output logic                    ds_to_es_valid,
    output logic [31:0]             ds_inst,
    output logic [PC_W-1:0]         ds_pc,
    output logic [4:0]              rs1,
    output logic [4:0]              rs2,
    output logic [4:0]              rd,
    input  logic                    es_wen,
    input  logic                    es_is_load,
    input  logic [4:0]              es_rd,
    input  logic                    ms_wen,
    input  logic [4:0]              ms_rd,
    output logic [1:0]              fwd_a_sel,
    output logic [1:0]              fwd_b_sel,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = 32 + PC_W;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          byp, head_valid, load_use, push, pop, push_store, pop_store;
    logic [BW-1:0] head_bus;

    always_comb begin
        byp = 1'b0;
`ifdef ID_QUEUE_BYPASS_EN
        byp = (count_q == '0) && fs_to_ds_valid && !flush;
`endif
        head_valid = byp || (count_q != '0);
        head_bus   = byp ? fs_to_ds_bus : mem_q[rd_ptr_q];
        ds_inst    = head_valid ? head_bus[BW-1:PC_W] : NOP;
        ds_pc      = head_valid ? head_bus[PC_W-1:0] : '0;
        rs1        = ds_inst[19:15];
        rs2        = ds_inst[24:20];
        rd         = ds_inst[11:7];

        // rs2 is compared for every format; a spurious stall is cheaper than decoding here
        load_use = es_is_load && es_wen && (es_rd != 5'd0) && (es_rd == rs1 || es_rd == rs2);

        fwd_a_sel = 2'd0;
        if (rs1 != 5'd0) begin
            if (es_wen && es_rd == rs1)      fwd_a_sel = 2'd1;
            else if (ms_wen && ms_rd == rs1) fwd_a_sel = 2'd2;
        end
        fwd_b_sel = 2'd0;
        if (rs2 != 5'd0) begin
            if (es_wen && es_rd == rs2)      fwd_b_sel = 2'd1;
            else if (ms_wen && ms_rd == rs2) fwd_b_sel = 2'd2;
        end

        ds_allowin     = (count_q != (AW+1)'(DEPTH));
        ds_to_es_valid = head_valid && !load_use && !flush;
        push           = fs_to_ds_valid && ds_allowin && !flush;
        pop            = ds_to_es_valid && es_allowin;
        // a bypassed head lives only on the input bus: consumed means never stored
        push_store     = push && !(byp && pop);
        pop_store      = pop && !byp;

        rd_ptr_d = rd_ptr_q + AW'(pop_store);
        wr_ptr_d = wr_ptr_q + AW'(push_store);
        count_d  = count_q + (AW+1)'(push_store) - (AW+1)'(pop_store);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
        count = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_store) mem_q[wr_ptr_q] <= fs_to_ds_bus;
    end
endmodule

// File: doc/ysyx_22040759_id_queue.md
# ysyx_22040759_id_queue

Decode-front buffer between IF and the instruction decoder/EX issue. It holds fetched instructions in a parametrised-depth FIFO and presents the head instruction with its register fields. It detects load-use hazards and generates per-operand forwarding selects. A branch-taken flush clears it in one cycle. It replaces the single-entry IF/ID register and its external hazard-unit stall path.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `PC_W`, 64: PC width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `fs_to_ds_valid` in 1: fetch bundle valid.
- `fs_to_ds_bus` in 32+PC_W: {inst[31:0], pc}.
- `ds_allowin` out 1: queue accepts a push this cycle.
- `es_allowin` in 1: EX accepts an instruction.
- `ds_to_es_valid` out 1: head instruction issuable.
- `ds_inst` out 32: head instruction.
- `ds_pc` out PC_W: head PC.
- `rs1`, `rs2`, `rd` out 5 each: head inst[19:15], [24:20], [11:7].
- `es_wen`, `es_is_load` in 1 each: EX-stage instruction writes rd / is a load.
- `es_rd` in 5: EX-stage destination.
- `ms_wen` in 1: MEM-stage instruction writes rd.
- `ms_rd` in 5: MEM-stage destination.
- `fwd_a_sel`, `fwd_b_sel` out 2 each: 0 = regfile, 1 = EX result, 2 = MEM result.
- `flush` in 1: branch taken; discard all contents.
- `count` out $clog2(DEPTH)+1: occupancy.

## Operation
- Circular FIFO with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a `count` register.
- `push = fs_to_ds_valid && ds_allowin && !flush`.
- `ds_allowin = (count != DEPTH)`. It is purely registered-state based and does not depend on `es_allowin`. A full queue refuses a push even when a pop occurs in the same cycle.
- `load_use = es_is_load && es_wen && es_rd!=0 && (es_rd==rs1 || es_rd==rs2)`. `rs2` is checked for every format, which is deliberately conservative.
- `ds_to_es_valid = head_valid && !load_use && !flush`.
- `pop = ds_to_es_valid && es_allowin`.
- Push and pop in the same cycle leave `count` unchanged.
- With no head valid: `ds_inst = 32'h00000013` (nop), `ds_pc = 0`, and `rs1`/`rs2`/`rd` are decoded from that nop.
- Forwarding for operand A (B is identical using `rs2`):
  - `rs1 == 0` → 0.
  - `es_wen && es_rd == rs1` → 1.
  - `ms_wen && ms_rd == rs1` → 2.
  - otherwise → 0.
  - EX has priority over MEM.
- When `flush` is asserted:
  - next cycle: pointers = 0, `count` = 0;
  - the same-cycle push is dropped and the same-cycle pop is suppressed;
  - `flush` dominates push, pop and `load_use`.

## Timing
- Reset: `count` = 0, pointers = 0, `ds_to_es_valid` = 0, `ds_allowin` = 1, `ds_inst` = 32'h13, `ds_pc` = 0, `fwd_*_sel` = 0.
- Reset takes effect on the clock edge, including while the queue is mid-operation. Entry storage is not cleared.
- Minimum latency (without bypass): a push in cycle N makes the instruction issuable in cycle N+1.
- `load_use` blocks issue only while the load occupies EX. With no other stall this is exactly one cycle; afterwards the select resolves to 2 (MEM).
- Head outputs, `ds_to_es_valid` and `fwd_*_sel` are combinational from head and stage inputs. No registered output delay.

## Configuration
- `ID_QUEUE_BYPASS_EN` defined:
  - When `count == 0`, `fs_to_ds_valid` is asserted and `flush` is not, the incoming bundle is presented as the head in the same cycle (zero-latency).
  - If that bypassed instruction is popped, it is not written into the queue. Otherwise it is pushed normally.
  - Hazard and forwarding logic apply to the bypassed head.
- Undefined: the head is always the queue's stored entry, and latency is ≥1 cycle.

## Test plan
- Fill without issue: `DEPTH` = 4, `es_allowin` = 0, push 5 bundles → `count` = 4, `ds_allowin` = 0 after the 4th, 5th not accepted; then pop all → PCs issue in order 0x80000000, …04, …08, …0C.
- Load-use: head `add x3,x1,x2`; EX has `es_is_load` = 1, `es_wen` = 1, `es_rd` = 1 → `ds_to_es_valid` = 0 for one cycle; next cycle with `ms_rd` = 1, `ms_wen` = 1 → issues with `fwd_a_sel` = 2.
- Forward priority: `es_rd` = `ms_rd` = 5, both wen, head rs2 = 5 → `fwd_b_sel` = 1; head rs1 = 0 with `es_rd` = 0 → `fwd_a_sel` = 0.
- Flush with simultaneous push: `count` = 3, `flush` = 1 with `fs_to_ds_valid` = 1 → next cycle `count` = 0, `ds_inst` = 32'h13, `ds_to_es_valid` = 0.
- Wrap-around: run 10 push/pop pairs with `DEPTH` = 4 → order preserved, `count` ≤ 1, no loss.
- `ID_QUEUE_BYPASS_EN`: empty queue, push PC 0x80000010 with `es_allowin` = 1 → `ds_to_es_valid` = 1 in the same cycle, `count` stays 0. Without the macro → valid only in the next cycle.
